vga_scan_timing: RTL



---
 rtl/vga_scan_timing_if.sv | 23 ++
 rtl/vga_scan_timing.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/vga_scan_timing_if.sv
// Display-side bundle of the raster timing generator: mode/step controls in, raster and pulse outputs out.
interface vga_scan_timing_if;
  logic       run;
  logic       stepReq;
  logic [9:0] column;
  logic [8:0] row;
  logic       displayActive;
  logic       vblank;
  logic       hsync;
  logic       vsync;
  logic       drawRequest;
  logic       frameStart;

  modport master (
    input  run, stepReq,
    output column, row, displayActive, vblank, hsync, vsync, drawRequest, frameStart
  );

  modport slave (
    output run, stepReq,
    input  column, row, displayActive, vblank, hsync, vsync, drawRequest, frameStart
  );
endinterface

// File: rtl/vga_scan_timing.sv
// VGA raster timing (blanking first, then active) with Game of Life generation pulse scheduling.
// Define STEP_INPUT_EN to build the stepReq synchroniser / single-step path.
module vga_scan_timing #(
  parameter int unsigned H_ACTIVE       = 640,
  parameter int unsigned H_FRONT        = 16,
  parameter int unsigned H_SYNC         = 96,
  parameter int unsigned H_BACK         = 48,
  parameter int unsigned V_ACTIVE       = 480,
  parameter int unsigned V_FRONT        = 10,
  parameter int unsigned V_SYNC         = 2,
  parameter int unsigned V_BACK         = 33,
  parameter logic        SYNC_POL       = 1'b0,
  parameter int unsigned FRAMES_PER_GEN = 4
) (
  input  logic               clkDiv,
  input  logic               rst,
  vga_scan_timing_if.master  bus
);
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_BLANK  = V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_FRONT;
  localparam int unsigned VS_END   = V_FRONT + V_SYNC;
  localparam int unsigned CNT_W    = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

  typedef enum logic {ST_BLANK, ST_ACTIVE} state_t;

  state_t             r_state, w_state_nxt;
  logic [9:0]         r_col, w_col_nxt;
  logic [8:0]         r_row, w_row_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_hsync, r_vsync, r_de, r_fs, r_draw;
  logic               w_hsync_nxt, w_vsync_nxt, w_de_nxt, w_fs_nxt, w_draw_nxt;
  logic               w_frame_wrap, w_auto, w_step_due;

  // Next raster position; outputs are registered from it so all of them describe the same pixel.
  always_comb begin
    w_state_nxt  = r_state;
    w_col_nxt    = r_col + 10'd1;
    w_row_nxt    = r_row;
    w_frame_wrap = 1'b0;
    w_auto       = 1'b0;
    w_cnt_nxt    = r_cnt;
    if (r_col == 10'(H_TOTAL - 1)) begin
      w_col_nxt = '0;
      w_row_nxt = r_row + 9'd1;
      case (r_state)
        ST_BLANK: if (r_row == 9'(V_BLANK - 1)) begin
          w_state_nxt = ST_ACTIVE;
          w_row_nxt   = '0;
        end
        ST_ACTIVE: if (r_row == 9'(V_ACTIVE - 1)) begin
          w_state_nxt  = ST_BLANK;
          w_row_nxt    = '0;
          w_frame_wrap = 1'b1;
        end
        default: ;
      endcase
    end

    w_hsync_nxt = (w_col_nxt >= 10'(HS_START) && w_col_nxt < 10'(HS_END)) ? SYNC_POL : ~SYNC_POL;
    w_vsync_nxt = (w_state_nxt == ST_BLANK && w_row_nxt >= 9'(VS_START) && w_row_nxt < 9'(VS_END))
                  ? SYNC_POL : ~SYNC_POL;
    w_de_nxt    = (w_state_nxt == ST_ACTIVE) && (w_col_nxt < 10'(H_ACTIVE));
    w_fs_nxt    = (w_state_nxt == ST_ACTIVE) && (w_row_nxt == '0) && (w_col_nxt == '0);

    // Frame counter only moves on an active->blanking wrap; run=0 parks it at zero.
    if (!bus.run) begin
      w_cnt_nxt = '0;
    end else if (w_frame_wrap) begin
      if (r_cnt == CNT_W'(FRAMES_PER_GEN - 1)) begin
        w_auto    = 1'b1;
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
    w_draw_nxt = w_frame_wrap && (w_auto || w_step_due);
  end

  always_ff @(posedge clkDiv or posedge rst) begin
    if (rst) begin
      r_state <= ST_BLANK;
      r_col   <= '0;
      r_row   <= '0;
      r_cnt   <= '0;
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_de    <= 1'b0;
      r_fs    <= 1'b0;
      r_draw  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hsync <= w_hsync_nxt;
      r_vsync <= w_vsync_nxt;
      r_de    <= w_de_nxt;
      r_fs    <= w_fs_nxt;
      r_draw  <= w_draw_nxt;
    end
  end

`ifdef STEP_INPUT_EN
  logic [1:0] r_sync;
  logic       r_sync_d, r_pending, w_step_edge;

  assign w_step_edge = r_sync[1] & ~r_sync_d;
  assign w_step_due  = r_pending;

  // Button edges latch a pending step; an edge seen while a pulse is issued or out is absorbed by it.
  always_ff @(posedge clkDiv or posedge rst) begin
    if (rst) begin
      r_sync    <= '0;
      r_sync_d  <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], bus.stepReq};
      r_sync_d <= r_sync[1];
      if (w_draw_nxt)
        r_pending <= 1'b0;
      else if (w_step_edge && !r_draw)
        r_pending <= 1'b1;
    end
  end
`else
  logic w_unused_step;
  assign w_unused_step = bus.stepReq;
  assign w_step_due    = 1'b0;
`endif

  assign bus.column        = r_col;
  assign bus.row           = r_row;
  assign bus.vblank        = (r_state == ST_BLANK);
  assign bus.displayActive = r_de;
  assign bus.hsync         = r_hsync;
  assign bus.vsync         = r_vsync;
  assign bus.drawRequest   = r_draw;
  assign bus.frameStart    = r_fs;
endmodule
